// File: rtl/vm2002_supplier_loader.sv
// Supplier-side transmitter for the VM2002 vending machine: buffers restock
// requests and replays them as single-cycle transactions of at most 15 units.
package vm2002_common_pkg;
  typedef logic [2:0] item_t;
endpackage

module vm2002_supplier_loader
  import vm2002_common_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     hrst,
  input  logic                     srst,
  input  logic                     load_en,
  input  logic                     req_valid,
  input  item_t                    req_item,
  input  logic [7:0]               req_count,
  input  logic [7:0]               req_cost,
  output logic                     req_ready,
  output logic                     valid,
  output item_t                    item,
  output logic [3:0]               count,
  output logic [7:0]               cost,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               tx_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Valid/ready: a request is accepted on any edge where req_valid && req_ready;
  // valid is a one-cycle strobe with no back-pressure from the machine.

  item_t        mem_item  [DEPTH];
  logic [7:0]   mem_count [DEPTH];
  logic [7:0]   mem_cost  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [1:0]    state;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    remaining;
  item_t         w_item;
  logic [7:0]    w_cost;

  item_t         head_item;
  logic [7:0]    head_count;
  logic [7:0]    head_cost;
  logic [3:0]    head_chunk;
  logic [3:0]    rem_chunk;
  logic          gap_done;
  logic          start_req;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign push       = req_valid && !full;
  assign pop        = start_req;
  assign req_ready  = !full;
  assign fifo_level = level;
  assign busy       = (state != ST_IDLE) || !empty;

  assign head_item  = mem_item[rd_ptr];
  assign head_count = mem_count[rd_ptr];
  assign head_cost  = mem_cost[rd_ptr];

  always_comb begin
    head_chunk = (head_count > 8'd15) ? 4'd15 : head_count[3:0];
    rem_chunk  = (remaining > 8'd15) ? 4'd15 : remaining[3:0];
    gap_done   = (state == ST_GAP) && (gap_cnt == '0);
    // A new request may start from IDLE, or straight out of a finished gap
    // once the current request has no chunks left.
    start_req  = load_en && !empty &&
                 ((state == ST_IDLE) || (gap_done && (remaining == '0)));
  end

  always_ff @(posedge clk) begin
    if (push && !srst) begin
      mem_item[wr_ptr]  <= req_item;
      mem_count[wr_ptr] <= req_count;
      mem_cost[wr_ptr]  <= req_cost;
    end
  end

  always_ff @(posedge clk or negedge hrst) begin
    if (!hrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge hrst) begin
    if (!hrst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      remaining <= '0;
      w_item    <= '0;
      w_cost    <= '0;
      valid     <= 1'b0;
      item      <= '0;
      count     <= '0;
      cost      <= '0;
      tx_total  <= '0;
    end else if (srst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      remaining <= '0;
      w_item    <= '0;
      w_cost    <= '0;
      valid     <= 1'b0;
      item      <= '0;
      count     <= '0;
      cost      <= '0;
      tx_total  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (start_req) begin
            w_item    <= head_item;
            w_cost    <= head_cost;
            valid     <= 1'b1;
            item      <= head_item;
            cost      <= head_cost;
            count     <= head_chunk;
            remaining <= head_count - {4'd0, head_chunk};
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          valid    <= 1'b0;
          tx_total <= tx_total + 8'd1;
          gap_cnt  <= GAP_LOAD;
          state    <= ST_GAP;
        end
        ST_GAP: begin
          valid <= 1'b0;
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (remaining != '0) begin
            // Remaining chunks of an accepted request go out even if load_en drops.
            valid     <= 1'b1;
            item      <= w_item;
            cost      <= w_cost;
            count     <= rem_chunk;
            remaining <= remaining - {4'd0, rem_chunk};
            state     <= ST_SEND;
          end else if (start_req) begin
            w_item    <= head_item;
            w_cost    <= head_cost;
            valid     <= 1'b1;
            item      <= head_item;
            cost      <= head_cost;
            count     <= head_chunk;
            remaining <= head_count - {4'd0, head_chunk};
            state     <= ST_SEND;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm2002_supplier_loader.sv
// Bench for vm2002_supplier_loader: directed scenarios plus randomized requests
// checked against a chunk-list model with a gap/tx_total monitor.
`timescale 1ns/1ps
module tb_vm2002_supplier_loader;
  import vm2002_common_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk       = 1'b0;
  logic       hrst      = 1'b0;
  logic       srst      = 1'b0;
  logic       load_en   = 1'b0;
  logic       req_valid = 1'b0;
  item_t      req_item  = '0;
  logic [7:0] req_count = '0;
  logic [7:0] req_cost  = '0;
  logic       req_ready;
  logic       valid;
  item_t      item;
  logic [3:0] count;
  logic [7:0] cost;
  logic       busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] tx_total;

  vm2002_supplier_loader #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .hrst(hrst), .srst(srst), .load_en(load_en),
    .req_valid(req_valid), .req_item(req_item), .req_count(req_count), .req_cost(req_cost),
    .req_ready(req_ready), .valid(valid), .item(item), .count(count), .cost(cost),
    .busy(busy), .fifo_level(fifo_level), .tx_total(tx_total)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state: entry = {exact_gap, item[2:0], count[3:0], cost[7:0]}
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  tx_model;
  logic [7:0]  tx_expected;
  int          low_run;
  logic        prev_valid;
  logic [15:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    tx_model    = 8'd0;
    tx_expected = 8'd0;
    low_run     = 1000;
    prev_valid  = 1'b0;
  endtask

  // Splits a request into transactions of at most 15 units; count 0 is one transaction.
  function automatic void add_model(input item_t it, input logic [7:0] cnt,
                                    input logic [7:0] cst, input bit exact_first);
    int n;
    bit first;
    n = int'(cnt);
    first = 1'b1;
    do begin
      int c;
      logic ex;
      c = (n > 15) ? 15 : n;
      ex = first ? exact_first : 1'b1;
      exp_q.push_back({ex, it, 4'(c), cst});
      tx_expected = tx_expected + 8'd1;
      n = n - c;
      first = 1'b0;
    end while (n > 0);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (valid) begin
      check("pulse_width", 32'(prev_valid), 32'(0));
      check("tx_total_run", 32'(tx_total), 32'(tx_model));
      check("exp_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("item", 32'(item), 32'(mon_e[14:12]));
        check("count", 32'(count), 32'(mon_e[11:8]));
        check("cost", 32'(cost), 32'(mon_e[7:0]));
        if (mon_e[15]) check("gap_exact", 32'(low_run), 32'(GAP));
        else check("gap_min", 32'(low_run >= GAP), 32'(1));
      end
      tx_model = tx_model + 8'd1;
      low_run = 0;
    end else if (low_run < 100000) begin
      low_run++;
    end
    prev_valid = valid;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hrst();
    hrst = 1'b0;
    reset_model();
    tick();
    hrst = 1'b1;
    tick();
  endtask

  task automatic push_req(input item_t it, input logic [7:0] cnt, input logic [7:0] cst,
                          input bit exp_acc, input bit exact_first, input bit model_add);
    req_valid = 1'b1;
    req_item  = it;
    req_count = cnt;
    req_cost  = cst;
    check("req_ready", 32'(req_ready), 32'(exp_acc));
    if (exp_acc && model_add) add_model(it, cnt, cst, exact_first);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'(1));
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < budget);
    check("valid_seen", 32'(valid), 32'(1));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'(1));
  endtask

  task automatic wait_exp_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("exp_empty", 32'(exp_q.size()), 32'(0));
  endtask

  function automatic logic [7:0] rand_count();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'($urandom_range(1, 15));
      2:       return 8'($urandom_range(16, 255));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    reset_model();
    tick();
    tick();
    hrst = 1'b1;
    tick();
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_tx_total", 32'(tx_total), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));

    // 40 units split 15/15/10, with first-pulse latency
    load_en = 1'b1;
    push_req(3'd2, 8'd40, 8'h19, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("latency_early", 32'(valid), 32'(0));
    @(negedge clk);
    check("latency", 32'(valid), 32'(1));
    drain(100);
    check("t40_tx_total", 32'(tx_total), 32'(3));
    check("t40_busy", 32'(busy), 32'(0));

    // asynchronous reset while valid is high
    push_req(3'd5, 8'd40, 8'h77, 1'b1, 1'b0, 1'b1);
    wait_valid(20);
    #1;
    hrst = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'(0));
    check("arst_count", 32'(count), 32'(0));
    check("arst_cost", 32'(cost), 32'(0));
    check("arst_item", 32'(item), 32'(0));
    check("arst_tx_total", 32'(tx_total), 32'(0));
    check("arst_ready", 32'(req_ready), 32'(1));
    check("arst_busy", 32'(busy), 32'(0));
    reset_model();
    tick();
    hrst = 1'b1;
    tick();

    // back-to-back requests including a count-0 cost update
    push_req(3'd1, 8'd5, 8'h21, 1'b1, 1'b0, 1'b1);
    push_req(3'd3, 8'd0, 8'h42, 1'b1, 1'b1, 1'b1);
    drain(100);
    check("b2b_tx_total", 32'(tx_total), 32'(2));

    // fill with load_en low, overflow ignored, then release in order
    do_hrst();
    load_en = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(item_t'(i + 1), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
               1'b1, i != 0, 1'b1);
    check("full_level", 32'(fifo_level), 32'(4));
    push_req(3'd7, 8'd9, 8'h55, 1'b0, 1'b0, 1'b1);
    check("full_level_hold", 32'(fifo_level), 32'(4));
    check("full_busy", 32'(busy), 32'(1));
    repeat (5) tick();
    load_en = 1'b1;
    drain(200);
    check("full_tx_total", 32'(tx_total), 32'(4));
    check("full_empty", 32'(fifo_level), 32'(0));

    // load_en dropped after the first chunk: request completes, queue waits
    do_hrst();
    push_req(3'd4, 8'd30, 8'h30, 1'b1, 1'b0, 1'b1);
    push_req(3'd5, 8'd3, 8'h31, 1'b1, 1'b0, 1'b0);
    wait_valid(20);
    #1;
    load_en = 1'b0;
    wait_exp_empty(50);
    repeat (10) tick();
    check("hold_level", 32'(fifo_level), 32'(1));
    check("hold_busy", 32'(busy), 32'(1));
    check("hold_tx_total", 32'(tx_total), 32'(2));
    add_model(3'd5, 8'd3, 8'h31, 1'b0);
    load_en = 1'b1;
    drain(100);
    check("hold_tx_total2", 32'(tx_total), 32'(3));

    // synchronous clear during a gap, also masking a same-cycle push
    do_hrst();
    push_req(3'd6, 8'd40, 8'h66, 1'b1, 1'b0, 1'b1);
    push_req(3'd2, 8'd8, 8'h67, 1'b1, 1'b0, 1'b0);
    wait_valid(20);
    tick();
    srst = 1'b1;
    req_valid = 1'b1;
    req_item = 3'd1;
    req_count = 8'd1;
    req_cost = 8'h01;
    tick();
    srst = 1'b0;
    req_valid = 1'b0;
    reset_model();
    check("srst_level", 32'(fifo_level), 32'(0));
    check("srst_tx_total", 32'(tx_total), 32'(0));
    check("srst_busy", 32'(busy), 32'(0));
    check("srst_valid", 32'(valid), 32'(0));
    repeat (20) tick();
    check("srst_quiet", 32'(tx_total), 32'(0));

    // tx_total wrap: 15 x 17 chunks + 1
    do_hrst();
    for (int i = 0; i < 15; i++) begin
      wait_ready();
      push_req(item_t'(i), 8'd255, 8'(i), 1'b1, 1'b0, 1'b1);
    end
    wait_ready();
    push_req(3'd0, 8'd0, 8'hee, 1'b1, 1'b0, 1'b1);
    drain(2000);
    check("wrap_tx_total", 32'(tx_total), 32'(0));

    // randomized requests with load_en toggling
    do_hrst();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_en = 1'b0;
        repeat ($urandom_range(1, 8)) tick();
        load_en = 1'b1;
      end
      wait_ready();
      push_req(item_t'($urandom_range(0, 7)), rand_count(), 8'($urandom_range(0, 255)),
               1'b1, 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    load_en = 1'b1;
    drain(6000);
    check("rand_tx_total", 32'(tx_total), 32'(tx_expected));

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
